pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Parametrised pipeline stall/flush controller for the CPU core. Merges per-stage
//  stall requests into a cumulative stall mask, turns committed exception causes into
//  a registered PC redirect, and holds flush for a configurable number of cycles.
//  Sits beside the pipeline registers; fed by the stages, CP0 and the bus interface.
// PARAMETERS
//  NUM_STAGES   6             number of stall bits; bit0 = PC, ascending toward WB
//  FLUSH_CYCLES 1             cycles flush/new_pc are held after a redirect (>=1)
//  INT_VECTOR   32'h00000020  redirect target for interrupt cause
//  EXC_VECTOR   32'h00000040  redirect target for synchronous exceptions
//  WDOG_LIMIT   1024          consecutive stall cycles before watchdog fires (opt.)
// PORTS
//  clk               in   1           core clock
//  rst               in   1           synchronous reset, active-high
//  stall_req         in   NUM_STAGES  per-stage stall request; bit k from stage k
//  exception_type_i  in   32          committed exception cause; 0 = none
//  cp0_epc_i         in   32          EPC value for ERET
//  stall             out  NUM_STAGES  cumulative stall mask to pipeline registers
//  flush             out  1           flush all pipeline registers
//  new_pc            out  32          redirect target, valid while flush=1
//  busy              out  1           controller in FLUSH state
//  wdog_timeout      out  1           stall watchdog pulse (opt. feature)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, flush=0, new_pc=0, busy=0, stall=0,
//    counters=0, wdog_timeout=0. Reset mid-FLUSH aborts to IDLE next cycle.
//  - Stall mask (combinational, IDLE only): k = highest set bit of stall_req;
//    stall = (1<<(k+1))-1, i.e. bits 0..k set; stall_req=0 -> stall=0.
//    e.g. NUM_STAGES=6, stall_req=6'b001000 -> stall=6'b001111.
//  - FSM states IDLE, FLUSH; cnt width clog2(FLUSH_CYCLES+1).
//    IDLE: exception_type_i!=0 at edge -> FLUSH, flush=1, new_pc=target, cnt=1.
//    FLUSH: cnt==FLUSH_CYCLES -> IDLE, flush=0, new_pc=0; else cnt++, hold outputs.
//  - Latency: cause sampled in cycle N -> flush/new_pc asserted cycles N+1..N+FLUSH_CYCLES.
//  - Target map: 32'h01 -> INT_VECTOR; 32'h08/0A/0C/0D -> EXC_VECTOR;
//    32'h0E (ERET) -> cp0_epc_i captured at sample edge; any other nonzero -> EXC_VECTOR.
//  - Exception has priority over stall in the same cycle: stall=0 that cycle.
//  - In FLUSH: stall forced 0, exception_type_i ignored (pipeline being squashed);
//    busy=1. No new redirect until back in IDLE.
//  - new_pc held stable for the whole FLUSH window even if cp0_epc_i changes.
// CONFIGURATION
//  CTRL_STALL_WATCHDOG_EN defined: 32-bit counter increments each IDLE cycle with
//    stall!=0, clears when stall==0, on flush, or reset; when it reaches WDOG_LIMIT,
//    wdog_timeout pulses 1 cycle and counter clears.
//  Undefined: no counter logic; wdog_timeout tied 0.
// TESTING
//  T1 reset: rst=1 two cycles with stall_req=6'h3F, exception=32'h08 -> all outputs 0.
//  T2 stall priority: stall_req=6'b000100 -> 6'b000111; 6'b101100 -> 6'b111111; 0 -> 0.
//  T3 syscall: exception=32'h08 cycle N, FLUSH_CYCLES=3 -> flush=1,new_pc=0x40
//     N+1..N+3, busy=1, 0 at N+4; second cause at N+2 ignored.
//  T4 ERET: cp0_epc_i=0xBFC00100, exception=32'h0E, stall_req=6'h08 same cycle ->
//     stall=0, next cycle new_pc=0xBFC00100; EPC changed next cycle -> new_pc unchanged.
//  T5 reset mid-flush: rst=1 in FLUSH cycle 2 -> flush=0,busy=0 next edge; unknown
//     cause 32'h05 after reset -> new_pc=0x40; cause 32'h01 -> new_pc=0x20.
//  T6 watchdog (EN, WDOG_LIMIT=8): stall_req=6'h04 held 8 cycles -> one wdog_timeout
//     pulse; drop stall at cycle 5 -> no pulse; undefined macro -> always 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: cumulative stall mask, registered PC redirect on
// committed exceptions, flush held FLUSH_CYCLES cycles. Optional stall watchdog: CTRL_STALL_WATCHDOG_EN.
module pipeline_ctrl #(
  parameter int          NUM_STAGES   = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int          WDOG_LIMIT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [31:0]           exception_type_i,
  input  logic [31:0]           cp0_epc_i,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  busy,
  output logic                  wdog_timeout
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       new_pc_q, new_pc_nxt;
  logic [31:0]       target;
  logic              exc_valid;

  assign exc_valid = (exception_type_i != 32'h0);

  always_comb begin
    case (exception_type_i)
      32'h0000_0001:                               target = INT_VECTOR;
      32'h0000_0008, 32'h0000_000A,
      32'h0000_000C, 32'h0000_000D:                target = EXC_VECTOR;
      32'h0000_000E:                               target = cp0_epc_i;
      default:                                     target = EXC_VECTOR;
    endcase
  end

  // Stage k stalls when any stage at or above k requests; a pending redirect wins.
  always_comb begin
    stall = '0;
    if (!rst && state == IDLE && !exc_valid) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stall[k] = |(stall_req >> k);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    new_pc_nxt = new_pc_q;
    case (state)
      IDLE: begin
        if (exc_valid) begin
          state_nxt  = FLUSH;
          cnt_nxt    = CNT_W'(1);
          new_pc_nxt = target;
        end
      end
      FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYCLES)) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          new_pc_nxt = 32'h0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        new_pc_nxt = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all state updates at the same edge.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      new_pc_q <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      new_pc_q <= new_pc_nxt;
    end
  end

  assign flush  = (state == FLUSH);
  assign busy   = (state == FLUSH);
  assign new_pc = new_pc_q;

`ifdef CTRL_STALL_WATCHDOG_EN
  logic [31:0] wdog_cnt;

  // stall is already zero in FLUSH and on a redirect, so those clear the count too.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt     <= 32'h0;
      wdog_timeout <= 1'b0;
    end else if (stall != '0) begin
      if (wdog_cnt == 32'(WDOG_LIMIT - 1)) begin
        wdog_cnt     <= 32'h0;
        wdog_timeout <= 1'b1;
      end else begin
        wdog_cnt     <= wdog_cnt + 32'h1;
        wdog_timeout <= 1'b0;
      end
    end else begin
      wdog_cnt     <= 32'h0;
      wdog_timeout <= 1'b0;
    end
  end
`else
  logic [31:0] unused_wdog_limit;
  assign unused_wdog_limit = 32'(WDOG_LIMIT);
  assign wdog_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: reference model feeds a scoreboard queue of
// post-edge expectations; combinational stall is checked in-cycle.
module tb_pipeline_ctrl;

  localparam int NS = 6;
  localparam int FC = 3;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic [31:0]   exception_type_i;
  logic [31:0]   cp0_epc_i;
  logic [NS-1:0] stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          busy;
  logic          wdog_timeout;

  pipeline_ctrl #(
    .NUM_STAGES(NS), .FLUSH_CYCLES(FC),
    .INT_VECTOR(32'h0000_0020), .EXC_VECTOR(32'h0000_0040), .WDOG_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .exception_type_i(exception_type_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc), .busy(busy),
    .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        wdt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;

  // reference model state
  bit          m_flush = 0;
  int          m_cnt = 0;
  logic [31:0] m_pc = 0;
  int          m_wd = 0;
  bit          m_wdt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] smear(input logic [NS-1:0] r);
    logic [NS-1:0] m = r;
    for (int i = 0; i < NS; i++) m = m | (m >> 1);
    return m;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] exc, input logic [31:0] epc);
    if (exc == 32'h01) return 32'h20;
    if (exc == 32'h0E) return epc;
    return 32'h40;
  endfunction

  task automatic step(input logic r, input logic [NS-1:0] req,
                      input logic [31:0] exc, input logic [31:0] epc);
    exp_t          e;
    logic [NS-1:0] es;
    rst = r; stall_req = req; exception_type_i = exc; cp0_epc_i = epc;
    #1;
    es = (r || m_flush || exc != 0) ? '0 : smear(req);
    check("stall", {26'h0, stall}, {26'h0, es});
    if (r) begin
      m_flush = 0; m_cnt = 0; m_pc = 0; m_wd = 0; m_wdt = 0;
    end else begin
`ifdef CTRL_STALL_WATCHDOG_EN
      if (es != 0) begin
        m_wd++;
        m_wdt = (m_wd == WL);
        if (m_wdt) m_wd = 0;
      end else begin
        m_wd = 0; m_wdt = 0;
      end
`endif
      if (!m_flush) begin
        if (exc != 0) begin
          m_flush = 1; m_cnt = 1; m_pc = tgt(exc, epc);
        end
      end else if (m_cnt == FC) begin
        m_flush = 0; m_pc = 0;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back('{m_flush, m_pc, m_flush, m_wdt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("flush",  {31'h0, flush},        {31'h0, e.flush});
    check("new_pc", new_pc,                e.pc);
    check("busy",   {31'h0, busy},         {31'h0, e.busy});
    check("wdog",   {31'h0, wdog_timeout}, {31'h0, e.wdt});
    if (wdog_timeout === 1'b1) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 32'h0, 32'h0);
  endtask

  initial begin
    // T1 reset with active requests and cause
    step(1'b1, 6'h3F, 32'h08, 32'h0);
    step(1'b1, 6'h3F, 32'h08, 32'h0);

    // T2 stall mask patterns
    step(1'b0, 6'b000100, 32'h0, 32'h0);
    step(1'b0, 6'b101100, 32'h0, 32'h0);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    step(1'b0, 6'b000001, 32'h0, 32'h0);
    step(1'b0, 6'b100000, 32'h0, 32'h0);
    step(1'b0, 6'b001000, 32'h0, 32'h0);

    // T3 syscall, second cause during FLUSH ignored
    step(1'b0, 6'h00, 32'h08, 32'h0);
    step(1'b0, 6'h3F, 32'h00, 32'h0);
    step(1'b0, 6'h00, 32'h01, 32'h0);
    step(1'b0, 6'h00, 32'h00, 32'h0);
    idle(2);

    // T4 ERET beats stall; EPC change during FLUSH does not move new_pc
    step(1'b0, 6'h08, 32'h0E, 32'hBFC0_0100);
    step(1'b0, 6'h00, 32'h00, 32'h1234_5678);
    step(1'b0, 6'h00, 32'h00, 32'hDEAD_BEEF);
    idle(2);

    // T5 reset in FLUSH cycle 2, then unknown cause and interrupt
    step(1'b0, 6'h00, 32'h0A, 32'h0);
    step(1'b0, 6'h00, 32'h00, 32'h0);
    step(1'b1, 6'h00, 32'h00, 32'h0);
    step(1'b0, 6'h00, 32'h05, 32'h0);
    idle(4);
    step(1'b0, 6'h00, 32'h01, 32'h0);
    idle(4);
    step(1'b0, 6'h00, 32'h0D, 32'h0);
    idle(4);

    // T6 watchdog: short run first (no pulse), then a full run (one pulse)
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 6'h04, 32'h0, 32'h0);
    idle(2);
    for (int i = 0; i < WL; i++) step(1'b0, 6'h04, 32'h0, 32'h0);
    idle(2);
`ifdef CTRL_STALL_WATCHDOG_EN
    check("wdog_pulses", pulses, 1);
`else
    check("wdog_pulses", pulses, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
